// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that sequences one transaction at a time
// onto an external 4x3 latch memory through a SETUP/STROBE/HOLD/RESP cycle.
module mem_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WR0,
    input  logic       WR1,
    input  logic [1:0] ADDR0,
    input  logic [1:0] ADDR1,
    input  logic [2:0] WDATA0,
    input  logic [2:0] WDATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [2:0] RDATA0,
    output logic [2:0] RDATA1,
    output logic [1:0] MSEL,
    output logic [2:0] MD,
    output logic       ME,
    input  logic [2:0] MQ,
    output logic       BUSY,
    output logic       OWNER
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic [1:0] msel_q, msel_d;
    logic [2:0] md_q, md_d;
    logic       me_q, me_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [2:0] rdata0_q, rdata0_d;
    logic [2:0] rdata1_q, rdata1_d;
    logic       busy_q, busy_d;
    logic       grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            msel_q   <= 2'd0;
            md_q     <= 3'd0;
            me_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 3'd0;
            rdata1_q <= 3'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            msel_q   <= msel_d;
            md_q     <= md_d;
            me_q     <= me_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    // Outputs are registered, so each *_d reflects the value wanted in the
    // state being entered, not the state being left.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        msel_d   = msel_q;
        md_d     = md_q;
        me_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;
        grant    = (REQ0 && REQ1) ? ~last_q : REQ1;

        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_d = SETUP;
                    owner_d = grant;
                    wr_d    = grant ? WR1 : WR0;
                    msel_d  = grant ? ADDR1 : ADDR0;
                    md_d    = grant ? WDATA1 : WDATA0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d = STROBE;
                me_d    = wr_q;
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = RESP;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                if (!wr_q) begin
                    if (owner_q) rdata1_d = MQ;
                    else         rdata0_d = MQ;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ACK0   = ack0_q;
    assign ACK1   = ack1_q;
    assign RDATA0 = rdata0_q;
    assign RDATA1 = rdata1_q;
    assign MSEL   = msel_q;
    assign MD     = md_q;
    assign ME     = me_q;
    assign BUSY   = busy_q;
    assign OWNER  = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of requesters, round-robin and memory.
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1, WR0, WR1;
    logic [1:0] ADDR0, ADDR1;
    logic [2:0] WDATA0, WDATA1;
    logic       ACK0, ACK1, ME, BUSY, OWNER;
    logic [2:0] RDATA0, RDATA1, MD, MQ;
    logic [1:0] MSEL;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .MSEL(MSEL), .MD(MD), .ME(ME), .MQ(MQ), .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    // Latch memory: transparent while ME is high.
    logic [2:0] mem [4];
    always_latch begin
        if (ME) mem[MSEL] <= MD;
    end
    assign MQ = mem[MSEL];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic       p_pend [2];
    logic       p_wr   [2];
    logic [1:0] p_addr [2];
    logic [2:0] p_data [2];
    logic [2:0] ref_mem [4];
    logic [2:0] ref_rd [2];
    logic       last_m;
    logic [1:0] exp_msel;
    logic [2:0] exp_md;
    int         last_ack_cyc;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        REQ0 = p_pend[0]; WR0 = p_wr[0]; ADDR0 = p_addr[0]; WDATA0 = p_data[0];
        REQ1 = p_pend[1]; WR1 = p_wr[1]; ADDR1 = p_addr[1]; WDATA1 = p_data[1];
    endtask

    task automatic post(input int i, input logic wr, input logic [1:0] a, input logic [2:0] d);
        p_pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_data[i] = d;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, 4'(BUSY), 4'd0);
        chk({tag, "_me"}, 4'(ME), 4'd0);
        chk({tag, "_acks"}, {2'b0, ACK1, ACK0}, 4'd0);
        chk({tag, "_msel"}, 4'(MSEL), 4'(exp_msel));
        chk({tag, "_md"}, 4'(MD), 4'(exp_md));
    endtask

    // Runs one transaction starting in IDLE with inputs already driven.
    task automatic run_txn(input logic scramble);
        logic g;
        g = (p_pend[0] && p_pend[1]) ? ~last_m : p_pend[1];
        exp_msel = p_addr[g];
        exp_md   = p_data[g];
        step();
        chk("setup_busy", 4'(BUSY), 4'd1);
        chk("setup_owner", 4'(OWNER), 4'(g));
        chk("setup_msel", 4'(MSEL), 4'(exp_msel));
        chk("setup_md", 4'(MD), 4'(exp_md));
        chk("setup_me", 4'(ME), 4'd0);
        step();
        chk("strobe_me", 4'(ME), 4'(p_wr[g]));
        chk("strobe_msel", 4'(MSEL), 4'(exp_msel));
        if (p_wr[g]) ref_mem[p_addr[g]] = p_data[g];
        if (scramble) begin
            if (g) begin WR1 = 1'($urandom); ADDR1 = 2'($urandom); WDATA1 = 3'($urandom); end
            else   begin WR0 = 1'($urandom); ADDR0 = 2'($urandom); WDATA0 = 3'($urandom); end
        end
        step();
        chk("hold_me", 4'(ME), 4'd0);
        chk("hold_msel", 4'(MSEL), 4'(exp_msel));
        chk("hold_acks", {2'b0, ACK1, ACK0}, 4'd0);
        step();
        if (!p_wr[g]) ref_rd[g] = ref_mem[p_addr[g]];
        chk("resp_acks", {2'b0, ACK1, ACK0}, g ? 4'd2 : 4'd1);
        chk("resp_busy", 4'(BUSY), 4'd1);
        chk("resp_me", 4'(ME), 4'd0);
        chk("resp_msel", 4'(MSEL), 4'(exp_msel));
        chk("resp_md", 4'(MD), 4'(exp_md));
        chk("resp_rdata0", 4'(RDATA0), 4'(ref_rd[0]));
        chk("resp_rdata1", 4'(RDATA1), 4'(ref_rd[1]));
        last_ack_cyc = cyc;
        p_pend[g] = 1'b0;
        last_m = g;
        drive();
        step();
        idle_checks("post");
        chk("post_owner", 4'(OWNER), 4'(g));
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 2; i++) begin
            p_pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = 2'd0; p_data[i] = 3'd0; ref_rd[i] = 3'd0;
        end
        for (int i = 0; i < 4; i++) ref_mem[i] = 3'd0;
        last_m = 1'b1; exp_msel = 2'd0; exp_md = 3'd0;
        RST = 1'b1;
        drive();

        // Reset values, checked before any clock edge
        #3;
        chk("rst_busy", 4'(BUSY), 4'd0);
        chk("rst_me", 4'(ME), 4'd0);
        chk("rst_acks", {2'b0, ACK1, ACK0}, 4'd0);
        chk("rst_msel", 4'(MSEL), 4'd0);
        chk("rst_md", 4'(MD), 4'd0);
        chk("rst_owner", 4'(OWNER), 4'd0);
        chk("rst_rdata0", 4'(RDATA0), 4'd0);
        chk("rst_rdata1", 4'(RDATA1), 4'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Tie after reset: grants alternate starting with requester 0, 5 cycles apart
        post(0, 1'b1, 2'd0, 3'd3);
        post(1, 1'b1, 2'd1, 3'd2);
        drive();
        run_txn(1'b0);
        t0 = last_ack_cyc;
        run_txn(1'b0);
        chk("tie_gap_a", 4'(last_ack_cyc - t0), 4'd5);
        t0 = last_ack_cyc;
        post(0, 1'b1, 2'd0, 3'd1);
        post(1, 1'b1, 2'd1, 3'd6);
        drive();
        run_txn(1'b0);
        chk("tie_gap_b", 4'(last_ack_cyc - t0), 4'd5);
        t0 = last_ack_cyc;
        run_txn(1'b0);
        chk("tie_gap_c", 4'(last_ack_cyc - t0), 4'd5);

        // Write then read through requester 0
        post(0, 1'b1, 2'd2, 3'd5); drive(); run_txn(1'b0);
        post(0, 1'b0, 2'd2, 3'd0); drive(); run_txn(1'b0);
        chk("wr_rd_word2", 4'(RDATA0), 4'd5);

        // Isolation: requester 1 writes, requester 0 reads the same word
        post(1, 1'b1, 2'd3, 3'd7); drive(); run_txn(1'b0);
        post(0, 1'b0, 2'd3, 3'd0); drive(); run_txn(1'b0);
        chk("iso_rdata0", 4'(RDATA0), 4'd7);
        chk("iso_rdata1", 4'(RDATA1), 4'd0);

        // Inputs scrambled mid-transaction must not disturb it
        post(1, 1'b1, 2'd1, 3'd4); drive(); run_txn(1'b1);
        post(0, 1'b0, 2'd1, 3'd0); drive(); run_txn(1'b0);
        chk("stable_word1", 4'(RDATA0), 4'd4);

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            idle_checks("idle");
        end

        // Reset during STROBE of a write
        post(0, 1'b1, 2'd0, 3'd6); drive();
        step();
        step();
        chk("mid_me_before", 4'(ME), 4'd1);
        ref_mem[0] = 3'd6;
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_me", 4'(ME), 4'd0);
        chk("mid_rst_busy", 4'(BUSY), 4'd0);
        chk("mid_rst_acks", {2'b0, ACK1, ACK0}, 4'd0);
        chk("mid_rst_msel", 4'(MSEL), 4'd0);
        chk("mid_rst_rdata0", 4'(RDATA0), 4'd0);
        p_pend[0] = 1'b0; drive();
        ref_rd[0] = 3'd0; ref_rd[1] = 3'd0; last_m = 1'b1;
        exp_msel = 2'd0; exp_md = 3'd0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_checks("after_rst");
        end

        // Earlier words survive reset
        post(0, 1'b0, 2'd1, 3'd0); drive(); run_txn(1'b0);
        chk("keep_word1", 4'(RDATA0), 4'd4);
        post(1, 1'b0, 2'd2, 3'd0); drive(); run_txn(1'b0);
        chk("keep_word2", 4'(RDATA1), 4'd5);
        post(0, 1'b0, 2'd3, 3'd0); drive(); run_txn(1'b0);
        chk("keep_word3", 4'(RDATA0), 4'd7);

        // First tie after the mid-transaction reset goes to requester 0
        last_m = 1'b1;
        RST = 1'b1; #1; RST = 1'b0;
        ref_rd[0] = 3'd0; ref_rd[1] = 3'd0; exp_msel = 2'd0; exp_md = 3'd0;
        post(0, 1'b0, 2'd2, 3'd0);
        post(1, 1'b0, 2'd3, 3'd0);
        drive();
        run_txn(1'b0);
        run_txn(1'b0);

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_pend[i] && $urandom_range(0, 2) != 0)
                    post(i, 1'($urandom), 2'($urandom), 3'($urandom));
            end
            drive();
            if (!p_pend[0] && !p_pend[1]) begin
                step();
                idle_checks("rnd_idle");
            end else begin
                run_txn($urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
